gpio_cfg_serializer: RTL and testbench

- Upstream configuration stage for the user-project pad array.
- Holds one configuration word per pad: DM, slow, vtrip, IB mode, input disable, OE override, hold-override and analog enable/select/polarity bits.
- Shifts all words out to the per-pad GPIO control chain, bit-serially, on request, then pulses a load strobe.
- The chain latches the words and drives the pad-array control inputs.

---
 rtl/gpio_cfg_serializer.sv | 162 ++++++++++++++++
 tb/tb_gpio_cfg_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cfg_serializer.sv
// Per-pad GPIO configuration store that shifts every word bit-serially down the
// pad control chain on request and then pulses the chain's load strobe.
module gpio_cfg_serializer #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2,
    parameter logic [CFG_BITS-1:0] RESET_CFG = CFG_BITS'('h0403)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cfg_we,
    input  logic [5:0]          cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_wdata,
    output logic [CFG_BITS-1:0] cfg_rdata,
    input  logic                xfer_start,
    output logic                xfer_busy,
    output logic                xfer_done,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                serial_resetn
);

    localparam int PAD_W  = 6;
    localparam int BIT_W  = $clog2(CFG_BITS);
    localparam int CNT_W  = $clog2(NUM_PADS * CFG_BITS);
    localparam int HALF_W = 4;

    localparam logic [PAD_W-1:0]  LAST_PAD  = PAD_W'(NUM_PADS - 1);
    localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(CFG_BITS - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(NUM_PADS * CFG_BITS - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    state_t              state;
    logic [CFG_BITS-1:0] words [NUM_PADS];
    logic [HALF_W-1:0]   half_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [PAD_W-1:0]    pad_idx;
    logic [BIT_W-1:0]    bit_idx;
    logic [PAD_W-1:0]    next_pad;
    logic [BIT_W-1:0]    next_bit;
    logic                write_ok;
    logic                first_bit;

    assign write_ok = cfg_we && (cfg_addr < PAD_W'(NUM_PADS)) && !xfer_busy;

    always_comb begin
        cfg_rdata = '0;
        if (cfg_addr < PAD_W'(NUM_PADS))
            cfg_rdata = words[cfg_addr];
    end

    // A write landing on the same edge as the start must be the first bit shifted.
    always_comb begin
        first_bit = words[NUM_PADS-1][CFG_BITS-1];
        if (write_ok && cfg_addr == LAST_PAD)
            first_bit = cfg_wdata[CFG_BITS-1];
    end

    always_comb begin
        next_pad = pad_idx;
        next_bit = bit_idx - 1'b1;
        if (bit_idx == '0) begin
            next_pad = pad_idx - 1'b1;
            next_bit = TOP_BIT;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_PADS; i++)
                words[i] <= RESET_CFG;
        end else if (write_ok) begin
            words[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        serial_resetn <= ~wb_rst_i;
        if (wb_rst_i) begin
            state        <= IDLE;
            half_cnt     <= '0;
            bit_cnt      <= '0;
            pad_idx      <= LAST_PAD;
            bit_idx      <= TOP_BIT;
            xfer_busy    <= 1'b0;
            xfer_done    <= 1'b0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    xfer_done <= 1'b0;
                    if (xfer_start) begin
                        state        <= SHIFT_LO;
                        xfer_busy    <= 1'b1;
                        half_cnt     <= '0;
                        bit_cnt      <= '0;
                        pad_idx      <= LAST_PAD;
                        bit_idx      <= TOP_BIT;
                        serial_clock <= 1'b0;
                        serial_data  <= first_bit;
                    end
                end
                SHIFT_LO: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt     <= '0;
                        state        <= SHIFT_HI;
                        serial_clock <= 1'b1;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt     <= '0;
                        serial_clock <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state       <= LOAD;
                            serial_data <= 1'b0;
                            serial_load <= 1'b1;
                        end else begin
                            state       <= SHIFT_LO;
                            bit_cnt     <= bit_cnt + 1'b1;
                            pad_idx     <= next_pad;
                            bit_idx     <= next_bit;
                            serial_data <= words[next_pad][next_bit];
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt    <= '0;
                        state       <= DONE;
                        serial_load <= 1'b0;
                        xfer_busy   <= 1'b0;
                        xfer_done   <= 1'b1;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                DONE: begin
                    xfer_done <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Directed bench for gpio_cfg_serializer: a default build (CLK_DIV=2) and a
// CLK_DIV=1 build share clock and reset; monitors log the shifted bit stream.
module tb_gpio_cfg_serializer;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;

    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [12:0] cfg_wdata = '0;
    logic [12:0] cfg_rdata;
    logic        xfer_start = 1'b0;
    logic        xfer_busy, xfer_done, serial_clock, serial_data, serial_load, serial_resetn;

    logic        d1_we = 1'b0;
    logic [5:0]  d1_addr = '0;
    logic [12:0] d1_wdata = '0;
    logic [12:0] d1_rdata;
    logic        d1_start = 1'b0;
    logic        d1_busy, d1_done, d1_sclk, d1_sdata, d1_load, d1_resetn;

    int tests_run = 0;
    int tests_failed = 0;

    int busy_cycles = 0, done_pulses = 0, load_cycles = 0, rises = 0;
    logic prev_sclk = 1'b0;
    logic bit_log [0:4095];

    int d1_busy_cycles = 0, d1_done_pulses = 0, d1_load_cycles = 0, d1_rises = 0;
    int d1_zero_data = 0, d1_no_toggle = 0;
    logic d1_prev_sclk = 1'b0, d1_prev_busy = 1'b0;

    always #5 clk = ~clk;

    gpio_cfg_serializer dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (wb_rst_i),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_rdata     (cfg_rdata),
        .xfer_start    (xfer_start),
        .xfer_busy     (xfer_busy),
        .xfer_done     (xfer_done),
        .serial_clock  (serial_clock),
        .serial_data   (serial_data),
        .serial_load   (serial_load),
        .serial_resetn (serial_resetn)
    );

    gpio_cfg_serializer #(.CLK_DIV(1)) dut_div1 (
        .wb_clk_i      (clk),
        .wb_rst_i      (wb_rst_i),
        .cfg_we        (d1_we),
        .cfg_addr      (d1_addr),
        .cfg_wdata     (d1_wdata),
        .cfg_rdata     (d1_rdata),
        .xfer_start    (d1_start),
        .xfer_busy     (d1_busy),
        .xfer_done     (d1_done),
        .serial_clock  (d1_sclk),
        .serial_data   (d1_sdata),
        .serial_load   (d1_load),
        .serial_resetn (d1_resetn)
    );

    // Bits are captured on each rising edge of the chain clock, like the chain does.
    always @(negedge clk) begin
        if (xfer_busy) busy_cycles++;
        if (xfer_done) done_pulses++;
        if (serial_load) load_cycles++;
        if (serial_clock && !prev_sclk) begin
            if (rises < 4096) bit_log[rises] = serial_data;
            rises++;
        end
        prev_sclk = serial_clock;
    end

    always @(negedge clk) begin
        if (d1_busy) d1_busy_cycles++;
        if (d1_done) d1_done_pulses++;
        if (d1_load) d1_load_cycles++;
        if (d1_sclk && !d1_prev_sclk) d1_rises++;
        if (d1_busy && !d1_load && !d1_sdata) d1_zero_data++;
        if (d1_busy && d1_prev_busy && !d1_load && d1_sclk == d1_prev_sclk) d1_no_toggle++;
        d1_prev_sclk = d1_sclk;
        d1_prev_busy = d1_busy;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [5:0] addr, input logic [12:0] wdata, input logic start);
        cfg_we = we;
        cfg_addr = addr;
        cfg_wdata = wdata;
        xfer_start = start;
        tick();
        cfg_we = 1'b0;
        xfer_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int n;
        n = 0;
        while (done_pulses == base && n < budget) begin
            tick();
            n++;
        end
        check_output("done_within_budget", 32'(done_pulses != base), 32'd1);
    endtask

    function automatic logic [12:0] word_at(input int start);
        logic [12:0] w;
        w = '0;
        for (int i = 0; i < 13; i++)
            w = {w[11:0], bit_log[start + i]};
        return w;
    endfunction

    initial begin
        int b_busy, b_done, b_load, b_rise, n;

        // Reset state and readback
        tick(2);
        check_output("resetn_in_reset", 32'(serial_resetn), 32'd0);
        check_output("outputs_in_reset",
                     32'({xfer_busy, xfer_done, serial_clock, serial_data, serial_load}), 32'd0);
        for (int a = 0; a < 38; a++) begin
            cfg_addr = 6'(a);
            #1;
            check_output($sformatf("reset_word_%0d", a), 32'(cfg_rdata), 32'h0403);
        end
        cfg_addr = 6'd40;
        #1;
        check_output("readback_addr40", 32'(cfg_rdata), 32'h0);
        wb_rst_i = 1'b0;
        check_output("resetn_at_deassert", 32'(serial_resetn), 32'd0);
        tick();
        check_output("resetn_after_deassert", 32'(serial_resetn), 32'd1);
        check_output("outputs_idle",
                     32'({xfer_busy, xfer_done, serial_clock, serial_data, serial_load}), 32'd0);

        // Full transfer with distinctive first and last words
        apply_stimulus(1'b1, 6'd37, 13'h1ABC, 1'b0);
        apply_stimulus(1'b1, 6'd0, 13'h0001, 1'b0);
        apply_stimulus(1'b1, 6'd40, 13'h1555, 1'b0);
        cfg_addr = 6'd37;
        #1;
        check_output("write_pad37", 32'(cfg_rdata), 32'h1ABC);
        b_busy = busy_cycles; b_done = done_pulses; b_load = load_cycles; b_rise = rises;
        apply_stimulus(1'b0, 6'd0, 13'h0, 1'b1);
        check_output("busy_after_start", 32'(xfer_busy), 32'd1);
        wait_done(b_done, 2100);
        tick(5);
        check_output("t1_busy_cycles", 32'(busy_cycles - b_busy), 32'd1978);
        check_output("t1_done_pulses", 32'(done_pulses - b_done), 32'd1);
        check_output("t1_rises", 32'(rises - b_rise), 32'd494);
        check_output("t1_load_cycles", 32'(load_cycles - b_load), 32'd2);
        check_output("t1_first_word", 32'(word_at(b_rise)), 32'h1ABC);
        check_output("t1_second_word", 32'(word_at(b_rise + 13)), 32'h0403);
        check_output("t1_last_word", 32'(word_at(b_rise + 481)), 32'h0001);

        // Writes and start requests during a transfer are dropped
        b_busy = busy_cycles; b_done = done_pulses; b_rise = rises;
        apply_stimulus(1'b0, 6'd0, 13'h0, 1'b1);
        tick(100);
        apply_stimulus(1'b1, 6'd5, 13'h0000, 1'b1);
        cfg_addr = 6'd5;
        #1;
        check_output("busy_write_ignored", 32'(cfg_rdata), 32'h0403);
        wait_done(b_done, 2100);
        tick(50);
        check_output("t2_done_pulses", 32'(done_pulses - b_done), 32'd1);
        check_output("t2_busy_cycles", 32'(busy_cycles - b_busy), 32'd1978);
        check_output("t2_idle_after", 32'(xfer_busy), 32'd0);

        // Reset in the middle of a transfer
        b_done = done_pulses; b_rise = rises;
        apply_stimulus(1'b0, 6'd0, 13'h0, 1'b1);
        n = 0;
        while ((rises - b_rise) < 200 && n < 1000) begin
            tick();
            n++;
        end
        check_output("reached_bit200", 32'(rises - b_rise >= 200), 32'd1);
        wb_rst_i = 1'b1;
        tick();
        check_output("midreset_outputs",
                     32'({xfer_busy, xfer_done, serial_clock, serial_data, serial_load}), 32'd0);
        check_output("midreset_resetn", 32'(serial_resetn), 32'd0);
        wb_rst_i = 1'b0;
        cfg_addr = 6'd37;
        #1;
        check_output("midreset_pad37", 32'(cfg_rdata), 32'h0403);
        cfg_addr = 6'd0;
        #1;
        check_output("midreset_pad0", 32'(cfg_rdata), 32'h0403);
        tick(20);
        check_output("midreset_no_done", 32'(done_pulses - b_done), 32'd0);
        check_output("midreset_still_idle", 32'(xfer_busy), 32'd0);

        // Write and start on the same edge
        b_done = done_pulses; b_rise = rises;
        apply_stimulus(1'b1, 6'd37, 13'h0000, 1'b1);
        wait_done(b_done, 2100);
        tick(3);
        check_output("t4_first_word", 32'(word_at(b_rise)), 32'h0000);
        check_output("t4_second_word", 32'(word_at(b_rise + 13)), 32'h0403);
        check_output("t4_rises", 32'(rises - b_rise), 32'd494);

        // CLK_DIV=1 build with every word all-ones
        for (int a = 0; a < 38; a++) begin
            d1_we = 1'b1;
            d1_addr = 6'(a);
            d1_wdata = 13'h1FFF;
            tick();
        end
        d1_we = 1'b0;
        d1_addr = 6'd20;
        #1;
        check_output("d1_write_pad20", 32'(d1_rdata), 32'h1FFF);
        b_busy = d1_busy_cycles; b_done = d1_done_pulses; b_load = d1_load_cycles; b_rise = d1_rises;
        d1_start = 1'b1;
        tick();
        d1_start = 1'b0;
        n = 0;
        while (d1_done_pulses == b_done && n < 1200) begin
            tick();
            n++;
        end
        tick(3);
        check_output("d1_done_pulses", 32'(d1_done_pulses - b_done), 32'd1);
        check_output("d1_busy_cycles", 32'(d1_busy_cycles - b_busy), 32'd989);
        check_output("d1_rises", 32'(d1_rises - b_rise), 32'd494);
        check_output("d1_load_cycles", 32'(d1_load_cycles - b_load), 32'd1);
        check_output("d1_data_zero_cycles", 32'(d1_zero_data), 32'd0);
        check_output("d1_no_toggle_cycles", 32'(d1_no_toggle), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
